// File: rtl/mux_nx1_scan.sv
// Registered N:1 multiplexer with a manual select mode and a round-robin scan
// mode that dwells DWELL enabled cycles on each channel.
module mux_nx1_scan #(
  parameter int N     = 4,
  parameter int W     = 8,
  parameter int DWELL = 4,
  parameter int SW    = $clog2(N)
) (
  input  logic           CLK,
  input  logic           RST_N,
  input  logic           EN,
  input  logic           MODE,
  input  logic [SW-1:0]  S,
  input  logic [N*W-1:0] D,
  output logic [W-1:0]   Q,
  output logic [SW-1:0]  CH,
  output logic           VALID,
  output logic           WRAP,
  output logic           ERR
);

  localparam int CW = $clog2(DWELL) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DWELL - 1);
  localparam logic [SW-1:0] CH_LAST  = SW'(N - 1);

  logic [W-1:0]  q_q, q_d;
  logic [SW-1:0] ch_q, ch_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          valid_q, valid_d;
  logic          wrap_q, wrap_d;
  logic          err_q, err_d;

  logic [W-1:0]  d_ch [N];
  logic [SW-1:0] nch;
  logic [SW-1:0] sel_idx;
  logic [W-1:0]  sel_data;
  logic          dwell_done;
  logic          at_last;
  logic          s_ok;

  for (genvar gi = 0; gi < N; gi++) begin : g_unpack
    assign d_ch[gi] = D[gi*W +: W];
  end

  // S can only reach N or beyond when N is not a power of two.
  assign s_ok       = (32'(S) < 32'(N));
  assign dwell_done = (cnt_q == CNT_LAST);
  assign at_last    = (ch_q == CH_LAST);

  always_comb begin
    nch = ch_q;
    if (dwell_done) begin
      nch = at_last ? '0 : ch_q + SW'(1);
    end
  end

  assign sel_idx = MODE ? nch : S;

  // Compare against each legal index so an out-of-range S never indexes d_ch.
  always_comb begin
    sel_data = '0;
    for (int k = 0; k < N; k++) begin
      if (sel_idx == SW'(k)) sel_data = d_ch[k];
    end
  end

  always_comb begin
    q_d     = q_q;
    ch_d    = ch_q;
    cnt_d   = cnt_q;
    valid_d = 1'b0;
    wrap_d  = 1'b0;
    err_d   = 1'b0;
    if (EN) begin
      if (MODE) begin
        ch_d    = nch;
        q_d     = sel_data;
        valid_d = 1'b1;
        cnt_d   = dwell_done ? '0 : cnt_q + CW'(1);
        wrap_d  = dwell_done && at_last;
      end else begin
        cnt_d = '0;
        if (s_ok) begin
          ch_d    = S;
          q_d     = sel_data;
          valid_d = 1'b1;
        end else begin
          err_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      q_q     <= '0;
      ch_q    <= '0;
      cnt_q   <= '0;
      valid_q <= 1'b0;
      wrap_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      q_q     <= q_d;
      ch_q    <= ch_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
      wrap_q  <= wrap_d;
      err_q   <= err_d;
    end
  end

  assign Q     = q_q;
  assign CH    = ch_q;
  assign VALID = valid_q;
  assign WRAP  = wrap_q;
  assign ERR   = err_q;

endmodule
